// File: rtl/restoring_divider.sv
// Sequential radix-2 restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, with valid/ready handshakes on both sides.
module restoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] qsh_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] qsh_next;
  logic             accept;
  logic             last_step;

  // Handshake: a transfer happens on any rising edge where valid & ready are both
  // high; valid, once raised by a producer, holds its payload stable until that edge.
  assign in_ready  = (state == IDLE) & ~rst;
  assign accept    = in_valid & in_ready;
  assign last_step = (count == CW'(WIDTH - 1));

  // The partial remainder stays below the divisor, so trial[WIDTH] is a valid sign bit.
  always_comb begin
    shifted  = {rem_q, qsh_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvsr_q};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    qsh_next = {qsh_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      rem_q       <= '0;
      qsh_q       <= '0;
      dvsr_q      <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvsr_q <= divisor;
            count  <= '0;
            if (divisor == '0) begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= dividend[WIDTH-1:0];
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
            end else begin
              state <= CALC;
              rem_q <= dividend[2*WIDTH-1:WIDTH];
              qsh_q <= dividend[WIDTH-1:0];
            end
          end
        end
        CALC: begin
          rem_q <= rem_next;
          qsh_q <= qsh_next;
          count <= count + CW'(1);
          if (last_step) begin
            state       <= DONE;
            quotient    <= qsh_next;
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            out_valid   <= 1'b1;
          end
        end
        DONE: begin
          // Error results arrive here with out_valid low and raise it one edge later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
Sequential radix-2 restoring divider that performs the inverse of the team's pipelined 16x16 Wallace-tree multiplier. It takes a 2*WIDTH-bit dividend, such as a multiplier product, and a WIDTH-bit divisor. It returns a WIDTH-bit quotient and a WIDTH-bit remainder, one quotient bit per clock. It sits alongside the multiplier in the arithmetic datapath and uses valid/ready handshakes on both its input and output sides.

Parameters:
WIDTH, 16, divisor/quotient/remainder width; dividend is 2*WIDTH bits

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  dividend/divisor valid
in_ready  output  1  block can accept an operation
dividend  input  2*WIDTH  numerator
divisor  input  WIDTH  denominator
out_valid  output  1  result valid, held until accepted
out_ready  input  1  downstream accepts result
quotient  output  WIDTH  quotient
remainder  output  WIDTH  remainder
div_by_zero  output  1  divisor was zero
overflow  output  1  quotient does not fit in WIDTH bits (divisor != 0)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- While rst is high at a rising edge:
  - state goes to IDLE;
  - out_valid, quotient, remainder, div_by_zero and overflow all go to 0;
  - the internal remainder, quotient-shift and count registers clear.
- Reset during CALC or DONE aborts the operation; no result is ever presented for it.
- FSM states: IDLE, CALC, DONE.
- in_ready = (state==IDLE) & ~rst, combinational. in_ready is 0 in CALC and DONE.
- IDLE: at the edge where in_valid & in_ready, latch dividend and divisor, then:
  - if divisor==0: go to DONE. Outputs are quotient = all ones, remainder = dividend[WIDTH-1:0], div_by_zero=1, overflow=0.
  - else if dividend[2W-1:W] >= divisor: go to DONE. Outputs are quotient = all ones, remainder = 0, overflow=1, div_by_zero=0.
  - else: go to CALC with partial remainder = dividend[2W-1:W], quotient shift register = dividend[W-1:0], count=0.
- CALC, one step per edge:
  - trial = {rem, q_msb} - divisor, computed at W+1 bits;
  - if trial is non-negative, rem = trial[W-1:0] and shift in quotient bit 1;
  - otherwise rem = {rem, q_msb}[W-1:0] and shift in quotient bit 0;
  - count increments.
  - At the WIDTH-th step, go to DONE and register quotient, remainder, out_valid=1, and both flags=0.
- Latency, measured from the accepting edge k:
  - normal operation: out_valid is first high after edge k+WIDTH (16 cycles);
  - error cases: out_valid is high after edge k+1.
- DONE:
  - out_valid=1; quotient, remainder and flags are held stable while out_ready=0.
  - At the edge with out_valid & out_ready, out_valid goes to 0 and state goes to IDLE. Result outputs keep their last values.
  - The next operation can be accepted at the following edge, so the minimum issue interval is WIDTH+2 cycles.
- Arithmetic rules:
  - unsigned only;
  - in the normal case, dividend == quotient*divisor + remainder exactly, with remainder < divisor;
  - div_by_zero and overflow are mutually exclusive, and div_by_zero takes priority.
- in_valid while in_ready=0 is ignored; inputs are not sampled.

Test Plan:
- Normal: dividend=0x06260060, divisor=0x1234 -> quotient=0x5678, remainder=0x0000, flags 0. out_valid rises exactly 16 cycles after the accept edge.
- Remainder: dividend=0x06260065, divisor=0x1234 -> quotient=0x5678, remainder=0x0005. Max case: dividend=0xFFFE0001, divisor=0xFFFF -> quotient=0xFFFF, remainder=0x0000.
- Divide by zero: dividend=0x00001234, divisor=0x0000 -> div_by_zero=1, overflow=0, quotient=0xFFFF, remainder=0x1234. out_valid high one cycle after accept.
- Overflow: dividend=0x00020000, divisor=0x0002 -> overflow=1, div_by_zero=0, quotient=0xFFFF, remainder=0x0000. Boundary: dividend=0x0001FFFF, divisor=0x0002 -> quotient=0xFFFF, remainder=0x0001, no flag.
- Backpressure: after a result, hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, and a second in_valid is not accepted. Raise out_ready -> out_valid drops next edge, in_ready=1.
- Reset mid-operation: assert rst for 1 cycle at CALC step 8 -> all outputs 0, in_ready=1 after release, no stale result. Then issue 0xFFFE0001/0xFFFF -> correct result. Also confirm 10 random operand pairs checked against the quotient*divisor + remainder identity.
